rsnn_spi_responder: RTL and testbench
=====================================

# rsnn_spi_responder

SPI responder (mode 0, MSB first) that lets an external host load and read back the RSNN weight/config memory through the dedicated I/O pins. SCLK, CS_N and MOSI are oversampled in the system clock domain, framed into command/data bytes, and turned into single-cycle memory read and write strobes. Read data is shifted back on MISO. The block sits between the top-level pin mux (ui_in/uio) and the core's parameter memory.

## Interface
- ADDR_W, 7: memory address width. Must be ≤ 7, because the address travels in the command byte.
- DATA_W, 8: memory data width. Fixed at 8, one SPI byte per word.
- SYNC_STAGES, 2: synchronizer depth on sclk, cs_n and mosi. Must be ≥ 2.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from host, asynchronous to clk.
- cs_n  in  1  SPI chip select, active low.
- mosi  in  1  host-to-responder data.
- miso  out  1  responder-to-host data. Reset value 0.
- miso_oe  out  1  high while the synchronized cs_n is low; drives uio_oe. Reset value 0.
- mem_addr  out  ADDR_W  memory address. Reset value 0.
- mem_wdata  out  8  write data. Reset value 0.
- mem_we  out  1  one-cycle write strobe. Reset value 0.
- mem_re  out  1  one-cycle read strobe. Reset value 0.
- mem_rdata  in  8  read data, valid exactly 1 clk after mem_re.

## Operation
- Frame: cs_n falls, then byte0 = {rw, addr[6:0]}, then data bytes until cs_n rises. rw=1 is a write, rw=0 is a read. Address bits above ADDR_W are ignored.
- States: IDLE, CMD, WDATA, RDATA.
  - IDLE → CMD on synchronized cs_n falling.
  - CMD → WDATA or RDATA after 8 bits, selected by rw.
  - Any state → IDLE on synchronized cs_n rising.
- Sampling: mosi is sampled on the detected sclk rising edge; miso is updated on the detected sclk falling edge.
- Write: each completed data byte produces mem_we=1 for one cycle, with mem_addr and mem_wdata stable in that cycle. The address then increments.
- Read: the CMD→RDATA transition issues mem_re with addr. mem_rdata is loaded into the TX shift register the next cycle and MSB is placed on miso immediately. After each 8th rising edge in RDATA, the address increments, mem_re is issued, and the next byte is loaded the following cycle.
- Address wraps from 2^ADDR_W−1 to 0 in bursts.
- Partial byte at cs_n rise: discarded; no strobe; bit counter cleared.
- miso is 0 outside RDATA.
- Extra bits in a read frame are ignored.

## Timing
- SCLK high and low phases must each be ≥ 4 clk cycles. This ensures edge-detect plus the 1-cycle memory latency complete before the next SPI edge.
- Edge detection latency: SYNC_STAGES+1 clk cycles from pin to internal edge pulse.
- mem_we asserts 1 cycle after the detected rising edge of bit 8 of a data byte.
- mem_re asserts 1 cycle after the detected rising edge of bit 8 of the preceding byte.
- miso bit n+1 becomes valid within 1 clk of the detected falling edge following bit n.
- mem_we and mem_re are never both high in the same cycle.
- Reset mid-frame: all outputs return to their reset values at once and the state goes to IDLE. A frame already in progress is not resumed; the next cs_n falling edge starts a new frame.
- cs_n rising in the same clk as a byte completes: the byte counts, so its strobe fires, and then the state goes to IDLE.

## Structure
- Package rsnn_spi_pkg holds:
  - the state enum (IDLE, CMD, WDATA, RDATA);
  - the constants CMD_RW_BIT=7 and SPI_BYTE_W=8.
- Sub-module rsnn_sync_edge: an N-stage synchronizer plus rise/fall pulse outputs. It is instantiated for sclk and cs_n; mosi uses the synchronizer only.
- The top module holds the FSM, bit counter, RX/TX shift registers and address counter.

## Test plan
- Single write: cs_n low, bytes 0x85, 0x3C, cs_n high → exactly one mem_we with mem_addr=5 and mem_wdata=0x3C.
- Burst write with wrap: bytes 0xFF, 0x11, 0x22 → mem_we at addr 127 (data 0x11), then at addr 0 (data 0x22).
- Read burst: byte 0x0A, with the model returning mem[10]=0xA5 and mem[11]=0x5A → mem_re at addr 10, then 11; miso shifts out 0xA5, then 0x5A MSB first.
- Abort: cs_n rises after 5 bits of a write data byte following 0x82 → no mem_we; the next frame 0x82, 0x77 writes 0x77 to addr 2.
- Reset mid-read: rst_n pulsed low during bit 3 of the read byte → miso=0, miso_oe=0, no strobes; the next full frame operates normally.
- Minimum sclk timing: half-period exactly 4 clk cycles for the read and write scenarios above → identical results, no missed bits.

Source files
------------

// File: rtl/rsnn_spi_pkg.sv
// Shared types and constants for the RSNN SPI responder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rsnn_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } spi_state_e;

    localparam int CMD_RW_BIT = 7;
    localparam int SPI_BYTE_W = 8;

endpackage

// File: rtl/rsnn_sync_edge.sv
// Multi-stage synchronizer with registered rise/fall pulses for one async pin.
// Latency: STAGES+1 clk from pin change to pulse.
// Backpressure: none; pulses are single-cycle and unconditional.
module rsnn_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Resetting the chain low means a pin already low at reset release gives no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev_q;
            fall   <= ~sync_q[STAGES-1] & prev_q;
        end
    end

endmodule

// File: rtl/rsnn_spi_responder.sv
// SPI mode-0 responder turning host frames into parameter-memory read/write strobes.
// Latency: strobe 1 clk after the detected 8th sclk rise; read byte on miso 2 clk after mem_re.
// Backpressure: none; host must keep sclk phases >= 4 clk.
module rsnn_spi_responder
    import rsnn_spi_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES:0]  mosi_q;
    logic                  mosi_s;
    spi_state_e            state_q, state_d;
    logic [2:0]            bit_cnt;
    logic [SPI_BYTE_W-2:0] rx_sh;
    logic [SPI_BYTE_W-1:0] rx_byte;
    logic [SPI_BYTE_W-1:0] tx_sh;
    logic                  load_q;
    logic                  byte_done;

    rsnn_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    rsnn_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // One extra stage keeps mosi aligned with the registered sclk edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_q <= '0;
        else        mosi_q <= {mosi_q[SYNC_STAGES-1:0], mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES];

    assign rx_byte   = {rx_sh, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'(SPI_BYTE_W - 1));
    assign miso      = tx_sh[SPI_BYTE_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = CMD;
            CMD:     if (byte_done) state_d = rx_byte[CMD_RW_BIT] ? WDATA : RDATA;
            default: ;
        endcase
        if (cs_rise) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_oe   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            load_q    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            load_q <= mem_re;

            if (cs_fall)      miso_oe <= 1'b1;
            else if (cs_rise) miso_oe <= 1'b0;

            // Post-increment happens in the cycle after the strobe so addr is stable with we.
            if (mem_we) mem_addr <= mem_addr + 1'b1;

            if (state_q == IDLE) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sh   <= rx_byte[SPI_BYTE_W-2:0];
                if (byte_done) begin
                    case (state_q)
                        CMD: begin
                            mem_addr <= rx_byte[ADDR_W-1:0];
                            mem_re   <= ~rx_byte[CMD_RW_BIT];
                        end
                        WDATA: begin
                            mem_we    <= 1'b1;
                            mem_wdata <= rx_byte;
                        end
                        RDATA: begin
                            mem_addr <= mem_addr + 1'b1;
                            mem_re   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            // The fall right after a byte boundary must keep the freshly loaded MSB on the pin.
            if (state_q != RDATA)
                tx_sh <= '0;
            else if (load_q)
                tx_sh <= mem_rdata;
            else if (sclk_fall && bit_cnt != 3'd0)
                tx_sh <= {tx_sh[SPI_BYTE_W-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_rsnn_spi_responder.sv
// Directed bench for rsnn_spi_responder: writes, wrapping bursts, reads, aborts, reset mid-frame.
module tb_rsnn_spi_responder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       cs_n  = 1'b1;
    logic       mosi  = 1'b0;
    logic       miso, miso_oe, mem_we, mem_re;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] mem [128];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int both_cnt = 0;
    logic [6:0] we_addr_log [16];
    logic [7:0] we_data_log [16];
    logic [6:0] re_addr_log [16];

    always #5 clk = ~clk;

    rsnn_spi_responder #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    // Memory model: read data valid one clk after mem_re.
    always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

    always @(negedge clk) begin
        if (mem_we) begin
            if (we_cnt < 16) begin
                we_addr_log[we_cnt] = mem_addr;
                we_data_log[we_cnt] = mem_wdata;
            end
            we_cnt++;
        end
        if (mem_re) begin
            if (re_cnt < 16) re_addr_log[re_cnt] = mem_addr;
            re_cnt++;
        end
        if (mem_we && mem_re) both_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        we_cnt = 0;
        re_cnt = 0;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, input int hp, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            tick(hp);
            rx   = {rx[6:0], miso};
            sclk = 1'b1;
            tick(hp);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start(input int hp);
        cs_n = 1'b0;
        tick(hp);
    endtask

    task automatic frame_end(input int hp);
        tick(hp);
        cs_n = 1'b1;
        tick(2 * hp + 8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        if (miso !== 1'b0)      begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
        if (miso_oe !== 1'b0)   begin errors++; $display("FAIL reset_miso_oe: got %b expected 0", miso_oe); end
        if (mem_addr !== 7'd0)  begin errors++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
        if (mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 00", mem_wdata); end
        if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        if (mem_re !== 1'b0)    begin errors++; $display("FAIL reset_re: got %b expected 0", mem_re); end
        checks += 6;
        rst_n = 1'b1;
        tick(6);
    endtask

    task automatic test_single_write(input int hp);
        logic [7:0] rx;
        clear_logs();
        frame_start(hp);
        spi_bits(8'h85, 8, hp, rx);
        if (miso_oe !== 1'b1) begin errors++; $display("FAIL write_miso_oe hp%0d: got %b expected 1", hp, miso_oe); end
        spi_bits(8'h3C, 8, hp, rx);
        if (miso !== 1'b0) begin errors++; $display("FAIL write_miso_low hp%0d: got %b expected 0", hp, miso); end
        frame_end(hp);
        if (miso_oe !== 1'b0) begin errors++; $display("FAIL write_oe_off hp%0d: got %b expected 0", hp, miso_oe); end
        if (we_cnt !== 1) begin errors++; $display("FAIL write_we_count hp%0d: got %0d expected 1", hp, we_cnt); end
        if (we_addr_log[0] !== 7'd5) begin errors++; $display("FAIL write_addr hp%0d: got %0d expected 5", hp, we_addr_log[0]); end
        if (we_data_log[0] !== 8'h3C) begin errors++; $display("FAIL write_data hp%0d: got %h expected 3c", hp, we_data_log[0]); end
        if (re_cnt !== 0) begin errors++; $display("FAIL write_re_count hp%0d: got %0d expected 0", hp, re_cnt); end
        checks += 7;
    endtask

    task automatic test_burst_wrap(input int hp);
        logic [7:0] rx;
        clear_logs();
        frame_start(hp);
        spi_bits(8'hFF, 8, hp, rx);
        spi_bits(8'h11, 8, hp, rx);
        spi_bits(8'h22, 8, hp, rx);
        frame_end(hp);
        if (we_cnt !== 2) begin errors++; $display("FAIL wrap_we_count hp%0d: got %0d expected 2", hp, we_cnt); end
        if (we_addr_log[0] !== 7'd127) begin errors++; $display("FAIL wrap_addr0 hp%0d: got %0d expected 127", hp, we_addr_log[0]); end
        if (we_data_log[0] !== 8'h11) begin errors++; $display("FAIL wrap_data0 hp%0d: got %h expected 11", hp, we_data_log[0]); end
        if (we_addr_log[1] !== 7'd0) begin errors++; $display("FAIL wrap_addr1 hp%0d: got %0d expected 0", hp, we_addr_log[1]); end
        if (we_data_log[1] !== 8'h22) begin errors++; $display("FAIL wrap_data1 hp%0d: got %h expected 22", hp, we_data_log[1]); end
        checks += 5;
    endtask

    task automatic test_read_burst(input int hp);
        logic [7:0] rx0, rx1, rx2;
        clear_logs();
        frame_start(hp);
        spi_bits(8'h0A, 8, hp, rx0);
        spi_bits(8'h00, 8, hp, rx1);
        spi_bits(8'h00, 8, hp, rx2);
        frame_end(hp);
        if (rx1 !== 8'hA5) begin errors++; $display("FAIL read_byte0 hp%0d: got %h expected a5", hp, rx1); end
        if (rx2 !== 8'h5A) begin errors++; $display("FAIL read_byte1 hp%0d: got %h expected 5a", hp, rx2); end
        if (re_cnt !== 3) begin errors++; $display("FAIL read_re_count hp%0d: got %0d expected 3", hp, re_cnt); end
        if (re_addr_log[0] !== 7'd10) begin errors++; $display("FAIL read_addr0 hp%0d: got %0d expected 10", hp, re_addr_log[0]); end
        if (re_addr_log[1] !== 7'd11) begin errors++; $display("FAIL read_addr1 hp%0d: got %0d expected 11", hp, re_addr_log[1]); end
        if (we_cnt !== 0) begin errors++; $display("FAIL read_we_count hp%0d: got %0d expected 0", hp, we_cnt); end
        if (miso !== 1'b0) begin errors++; $display("FAIL read_miso_idle hp%0d: got %b expected 0", hp, miso); end
        checks += 7;
    endtask

    task automatic test_abort(input int hp);
        logic [7:0] rx;
        clear_logs();
        frame_start(hp);
        spi_bits(8'h82, 8, hp, rx);
        spi_bits(8'hFF, 5, hp, rx);
        frame_end(hp);
        if (we_cnt !== 0) begin errors++; $display("FAIL abort_no_we: got %0d expected 0", we_cnt); end
        checks++;
        frame_start(hp);
        spi_bits(8'h82, 8, hp, rx);
        spi_bits(8'h77, 8, hp, rx);
        frame_end(hp);
        if (we_cnt !== 1) begin errors++; $display("FAIL abort_next_count: got %0d expected 1", we_cnt); end
        if (we_addr_log[0] !== 7'd2) begin errors++; $display("FAIL abort_next_addr: got %0d expected 2", we_addr_log[0]); end
        if (we_data_log[0] !== 8'h77) begin errors++; $display("FAIL abort_next_data: got %h expected 77", we_data_log[0]); end
        checks += 3;
    endtask

    task automatic test_reset_mid_read(input int hp);
        logic [7:0] rx;
        frame_start(hp);
        spi_bits(8'h0A, 8, hp, rx);
        spi_bits(8'h00, 2, hp, rx);
        mosi = 1'b0;
        tick(hp);
        sclk = 1'b1;
        tick(1);
        rst_n = 1'b0;
        #1;
        if (miso !== 1'b0)    begin errors++; $display("FAIL rst_mid_miso: got %b expected 0", miso); end
        if (miso_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b expected 0", miso_oe); end
        if (mem_addr !== 7'd0) begin errors++; $display("FAIL rst_mid_addr: got %0d expected 0", mem_addr); end
        checks += 3;
        clear_logs();
        tick(3);
        rst_n = 1'b1;
        tick(hp);
        sclk = 1'b0;
        tick(hp);
        cs_n = 1'b1;
        tick(2 * hp + 8);
        if (we_cnt !== 0 || re_cnt !== 0) begin
            errors++;
            $display("FAIL rst_mid_strobes: got we=%0d re=%0d expected 0/0", we_cnt, re_cnt);
        end
        if (miso_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe_after: got %b expected 0", miso_oe); end
        checks += 2;
        test_read_burst(hp);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[10] = 8'hA5;
        mem[11] = 8'h5A;

        test_reset();
        test_single_write(6);
        test_burst_wrap(6);
        test_read_burst(6);
        test_abort(6);
        test_reset_mid_read(6);
        test_single_write(4);
        test_burst_wrap(4);
        test_read_burst(4);

        if (both_cnt !== 0) begin errors++; $display("FAIL we_re_overlap: got %0d cycles expected 0", both_cnt); end
        checks++;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
